alu_seq_32bit: RTL

Multi-cycle execute-stage ALU for the 32-bit MIPS datapath. It instantiates the gate-level 32-bit logic units (`and_32bit`, `or_32bit`, `xor_32bit`) and a 32-bit adder/subtractor. It accepts one operation per valid/ready handshake and computes single-cycle ops in one cycle. Logical shifts run iteratively, one bit per cycle. It presents a registered result with zero/overflow flags to the EX/MEM boundary.

---
 rtl/alu_seq_32bit.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_32bit.sv
// alu_seq_32bit
// Multi-cycle execute-stage ALU for the 32-bit MIPS datapath. Logic ops,
// ADD/SUB/SLT finish one cycle after accept. SLL/SRL shift one bit per
// cycle. The result and its zero/overflow flags are registered and held
// until the consumer takes them.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operation request
//   in_ready   high when an operation can be accepted (IDLE, out of reset)
//   alu_op     000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 SLT,
//              110 SLL, 111 SRL
//   a, b       operands (a is the shift source, b unused for shifts)
//   shamt      shift amount (shifts only)
//   out_valid  result valid
//   out_ready  consumer accepts result
//   result     registered result
//   zero       registered result==0
//   overflow   registered signed overflow (ADD/SUB only)

// Bitwise AND built from gate primitives.
module and_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  for (genvar i = 0; i < 32; i++) begin : g_bit
    and u_gate (y[i], a[i], b[i]);
  end
endmodule

// Bitwise OR built from gate primitives.
module or_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  for (genvar i = 0; i < 32; i++) begin : g_bit
    or u_gate (y[i], a[i], b[i]);
  end
endmodule

// Bitwise XOR built from gate primitives.
module xor_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  for (genvar i = 0; i < 32; i++) begin : g_bit
    xor u_gate (y[i], a[i], b[i]);
  end
endmodule

// 32-bit adder/subtractor. Subtraction is a + ~b + 1, so one overflow rule
// (operands agree in sign, sum disagrees) covers both ADD and SUB.
module addsub_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] sum,
  output logic        ovf
);
  logic [31:0] b_eff;

  assign b_eff = b ^ {32{sub}};
  assign sum   = a + b_eff + {31'b0, sub};
  assign ovf   = (a[31] == b_eff[31]) && (sum[31] != a[31]);
endmodule

module alu_seq_32bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  alu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;

  state_t      state;
  logic [31:0] shift_reg;
  logic [4:0]  count;
  logic        shift_right;

  logic [31:0] and_y;
  logic [31:0] or_y;
  logic [31:0] xor_y;
  logic [31:0] sum;
  logic        as_ovf;
  logic        do_sub;
  logic        is_shift;
  logic [31:0] op_result;
  logic        op_ovf;
  logic [31:0] shifted;

  and_32bit u_and (.a(a), .b(b), .y(and_y));
  or_32bit  u_or  (.a(a), .b(b), .y(or_y));
  xor_32bit u_xor (.a(a), .b(b), .y(xor_y));

  // SUB and SLT share the subtractor; only ADD adds.
  assign do_sub = (alu_op != OP_ADD);

  addsub_32bit u_addsub (
    .a   (a),
    .b   (b),
    .sub (do_sub),
    .sum (sum),
    .ovf (as_ovf)
  );

  assign is_shift  = alu_op[2] & alu_op[1];
  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);

  // Single-cycle result. The shift arm only matters for shamt==0, where the
  // result is the operand unchanged.
  always_comb begin
    op_result = a;
    op_ovf    = 1'b0;
    case (alu_op)
      OP_AND: op_result = and_y;
      OP_OR:  op_result = or_y;
      OP_XOR: op_result = xor_y;
      OP_ADD: begin
        op_result = sum;
        op_ovf    = as_ovf;
      end
      OP_SUB: begin
        op_result = sum;
        op_ovf    = as_ovf;
      end
      // Signed less-than must correct the sign bit when the subtract overflows.
      OP_SLT: op_result = {31'b0, sum[31] ^ as_ovf};
      default: op_result = a;
    endcase
  end

  // alu_op[0] selects SRL (1) or SLL (0); both zero fill.
  assign shifted = shift_right ? (shift_reg >> 1) : (shift_reg << 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      result      <= '0;
      zero        <= 1'b0;
      overflow    <= 1'b0;
      shift_reg   <= '0;
      count       <= '0;
      shift_right <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_shift && (shamt != 5'd0)) begin
              shift_reg   <= a;
              count       <= shamt;
              shift_right <= alu_op[0];
              state       <= SHIFT;
            end else begin
              result   <= op_result;
              zero     <= (op_result == 32'd0);
              overflow <= op_ovf;
              state    <= DONE;
            end
          end
        end
        SHIFT: begin
          shift_reg <= shifted;
          count     <= count - 5'd1;
          // count==1 means this edge performs the last bit of the shift.
          if (count == 5'd1) begin
            result   <= shifted;
            zero     <= (shifted == 32'd0);
            overflow <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
